// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and line constants for the UART transmit path.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
    localparam int DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous byte FIFO; push/pop are ignored when full/empty.
module uart_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [7:0]               din_i,
    input  logic                     pop_i,
    output logic [7:0]               dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic do_push, do_pop;

    assign level_o = wr_q - rd_q;
    assign full_o  = level_o == (AW + 1)'(DEPTH);
    assign empty_o = wr_q == rd_q;
    assign dout_o  = mem_q[rd_q[AW-1:0]];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter (LSB first) fed from a byte FIFO.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4167,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                          axis_clk,
    input  logic                          axis_rst_n,
    input  logic [7:0]                    s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic                          tx_en,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    state_e state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0] idx_q;
    logic stop_q, tx_q;
    logic [7:0] sh_q, fifo_dout;
    logic full, empty, pop, bit_end, last_stop;

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(axis_clk),
        .rst_n(axis_rst_n),
        .push_i(s_tvalid),
        .din_i(s_tdata),
        .pop_i(pop),
        .dout_o(fifo_dout),
        .full_o(full),
        .empty_o(empty),
        .level_o(fifo_level)
    );

    assign bit_end   = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign last_stop = bit_end & (stop_q == 1'(STOP_BITS - 1));
    // Popping at the final stop cycle chains frames with no idle gap.
    assign pop       = ~empty & tx_en & ((state_q == IDLE) | ((state_q == STOP) & last_stop));
    assign s_tready  = ~full;
    assign tx        = tx_q;
    assign busy      = (state_q != IDLE) | ~empty;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            sh_q    <= '0;
            tx_q    <= LINE_IDLE;
        end else if (pop) begin
            state_q <= START;
            sh_q    <= fifo_dout;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: tx_q <= LINE_IDLE;
                START: begin
                    cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
                    if (bit_end) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                        tx_q    <= sh_q[0];
                    end
                end
                DATA: begin
                    cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
                    if (bit_end && idx_q == 3'(DATA_BITS - 1)) begin
                        state_q <= STOP;
                        stop_q  <= 1'b0;
                        tx_q    <= LINE_IDLE;
                    end else if (bit_end) begin
                        idx_q <= idx_q + 1'b1;
                        sh_q  <= sh_q >> 1;
                        tx_q  <= sh_q[1];
                    end
                end
                STOP: begin
                    cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
                    if (last_stop) state_q <= IDLE;
                    else if (bit_end) stop_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: random and directed checks against a frame-level reference model.
module tb_uart_tx_serializer;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
    localparam int FR = 10 * CPB;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] s_tdata, d2;
    logic s_tvalid, tx_en, v2;
    logic s_tready, tx, busy, s_tready2, tx2, busy2;
    logic [2:0] fifo_level, fifo_level2;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mq[$];
    int t = -1;
    logic [7:0] cur = 8'h00;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
        .axis_clk(clk), .axis_rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .tx_en(tx_en), .tx(tx), .busy(busy), .fifo_level(fifo_level)
    );

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
        .axis_clk(clk), .axis_rst_n(rst_n), .s_tdata(d2), .s_tvalid(v2),
        .s_tready(s_tready2), .tx_en(1'b1), .tx(tx2), .busy(busy2), .fifo_level(fifo_level2)
    );

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Line level at position t of an 8N1 frame carrying cur.
    function automatic logic model_tx();
        int k;
        if (t < 0) return 1'b1;
        k = t / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur[k-1];
        return 1'b1;
    endfunction

    task automatic model_step();
        logic do_pop, do_push;
        do_pop = tx_en && mq.size() > 0 && (t < 0 || t == FR - 1);
        do_push = s_tvalid && mq.size() < DEPTH;
        if (do_pop) begin
            cur = mq.pop_front();
            t = 0;
        end else if (t >= 0) begin
            t++;
            if (t == FR) t = -1;
        end
        if (do_push) mq.push_back(s_tdata);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) model_step();
            else begin mq.delete(); t = -1; end
            @(negedge clk);
            if (!rst_n) begin mq.delete(); t = -1; end
            chk("tx", {7'd0, tx}, {7'd0, model_tx()});
            chk("busy", {7'd0, busy}, {7'd0, (t >= 0 || mq.size() > 0)});
            chk("fifo_level", {5'd0, fifo_level}, 8'(mq.size()));
            chk("s_tready", {7'd0, s_tready}, {7'd0, mq.size() < DEPTH});
        end
    end

    task automatic push(input logic [7:0] d);
        s_tvalid = 1'b1;
        s_tdata = d;
        @(posedge clk);
        #1 s_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", {7'd0, busy}, 8'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] a5_exp;
        logic [7:0] b55;
        a5_exp = 10'b1101001010;
        b55 = 8'h55;
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; tx_en = 1'b1; v2 = 1'b0; d2 = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // single 0xA5 frame, literal line levels
        push(8'hA5);
        for (int k = 0; k < 10; k++) begin
            repeat (k == 0 ? 2 : 4) @(posedge clk);
            @(negedge clk);
            chk("a5_bit", {7'd0, tx}, {7'd0, a5_exp[k]});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("a5_busy_last", {7'd0, busy}, 8'd1);
        @(posedge clk);
        @(negedge clk);
        chk("a5_busy_done", {7'd0, busy}, 8'd0);
        // six back-to-back pushes from reset
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        s_tvalid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            s_tdata = 8'h10 + 8'(n);
            @(posedge clk);
            #1;
        end
        s_tdata = 8'h15;
        chk("full_tready", {7'd0, s_tready}, 8'd0);
        chk("full_level", {5'd0, fifo_level}, 8'd4);
        for (int i = 0; i < 200 && !s_tready; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1 s_tvalid = 1'b0;
        drain();
        // tx_en gating
        tx_en = 1'b0;
        push(8'h3C);
        push(8'h81);
        repeat (10) @(posedge clk);
        #1;
        chk("hold_tx", {7'd0, tx}, 8'd1);
        chk("hold_level", {5'd0, fifo_level}, 8'd2);
        chk("hold_busy", {7'd0, busy}, 8'd1);
        tx_en = 1'b1;
        drain();
        // async reset in the middle of a data bit
        push(8'hFF);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tx", {7'd0, tx}, 8'd1);
        chk("rst_level", {5'd0, fifo_level}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push(8'h00);
        drain();
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            s_tvalid = $urandom_range(0, 3) == 0;
            s_tdata = 8'($urandom);
            if ($urandom_range(0, 31) == 0) tx_en = ~tx_en;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        tx_en = 1'b1;
        drain();
        // two stop bits: two contiguous 0x55 frames, 88 cycles total
        v2 = 1'b1;
        d2 = 8'h55;
        repeat (2) @(posedge clk);
        #1 v2 = 1'b0;
        for (int k = 0; k < 22; k++) begin
            int j;
            logic e;
            j = k % 11;
            e = (j == 0) ? 1'b0 : (j <= 8) ? b55[j-1] : 1'b1;
            repeat (k == 0 ? 1 : 4) @(posedge clk);
            @(negedge clk);
            chk("stop2_bit", {7'd0, tx2}, {7'd0, e});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stop2_busy_last", {7'd0, busy2}, 8'd1);
        @(posedge clk);
        @(negedge clk);
        chk("stop2_busy_done", {7'd0, busy2}, 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
